// File: rtl/melody_pkg.sv
// Shared types and the melody ROM for the melody sequencer.
// Each entry holds a note code and its length in beats minus one.
package melody_pkg;

  localparam int SONG_LEN = 42;
  localparam int IDX_W    = 6;

  typedef struct packed {
    logic [2:0] note;
    logic [1:0] beats_m1;
  } note_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_e;

  // Phrase-final entries hold for two beats.
  localparam note_entry_t SONG [0:SONG_LEN-1] = '{
    '{3'd1, 2'd0}, '{3'd1, 2'd0}, '{3'd5, 2'd0}, '{3'd5, 2'd0},
    '{3'd6, 2'd0}, '{3'd6, 2'd0}, '{3'd5, 2'd1},
    '{3'd4, 2'd0}, '{3'd4, 2'd0}, '{3'd3, 2'd0}, '{3'd3, 2'd0},
    '{3'd2, 2'd0}, '{3'd2, 2'd0}, '{3'd1, 2'd1},
    '{3'd5, 2'd0}, '{3'd5, 2'd0}, '{3'd4, 2'd0}, '{3'd4, 2'd0},
    '{3'd3, 2'd0}, '{3'd3, 2'd0}, '{3'd2, 2'd1},
    '{3'd5, 2'd0}, '{3'd5, 2'd0}, '{3'd4, 2'd0}, '{3'd4, 2'd0},
    '{3'd3, 2'd0}, '{3'd3, 2'd0}, '{3'd2, 2'd1},
    '{3'd1, 2'd0}, '{3'd1, 2'd0}, '{3'd5, 2'd0}, '{3'd5, 2'd0},
    '{3'd6, 2'd0}, '{3'd6, 2'd0}, '{3'd5, 2'd1},
    '{3'd4, 2'd0}, '{3'd4, 2'd0}, '{3'd3, 2'd0}, '{3'd3, 2'd0},
    '{3'd2, 2'd0}, '{3'd2, 2'd0}, '{3'd1, 2'd1}
  };

  function automatic logic [2:0] beats_of(note_entry_t e);
    return {1'b0, e.beats_m1} + 3'd1;
  endfunction

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// Cycle-within-beat counter plus remaining-beat counter for one note.
// Flags the gap start and the note end one cycle ahead of the edge.
module beat_timer #(
  parameter int TICK_DIV   = 1000000,
  parameter int GAP_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       load_i,
  input  logic [2:0] beats_i,
  input  logic       clear_i,
  output logic       wrap_o,
  output logic       note_end_o,
  output logic       gap_start_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GAP_AT = CW'(TICK_DIV - GAP_CYCLES - 1);

  logic [CW-1:0] cyc_q;
  logic [2:0]    beat_q;
  logic          last_beat;

  assign last_beat   = beat_q == 3'd1;
  assign wrap_o      = run_i && cyc_q == LAST;
  assign note_end_o  = wrap_o && last_beat;
  assign gap_start_o = (GAP_CYCLES != 0) && run_i
                    && last_beat && cyc_q == GAP_AT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      beat_q <= '0;
    end else if (clear_i) begin
      cyc_q  <= '0;
      beat_q <= '0;
    end else if (load_i) begin
      cyc_q  <= '0;
      beat_q <= beats_i;
    end else if (run_i) begin
      if (cyc_q == LAST) begin
        cyc_q  <= '0;
        beat_q <= beat_q - 3'd1;
      end else begin
        cyc_q <= cyc_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody ROM and drives a note code to the DDS.
// All outputs are registered; control decisions are made a cycle ahead.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICK_DIV   = 1000000,
  parameter int GAP_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [2:0] note_bin,
  output logic [5:0] note_idx,
  output logic       busy,
  output logic       done
);

  state_e            state_q;
  logic [2:0]        note_q;
  logic [IDX_W-1:0]  idx_q;
  logic              done_q;

  logic              run;
  logic              start_ok;
  logic              last_entry;
  logic [IDX_W-1:0]  nxt_idx;
  note_entry_t       nxt;
  logic              tm_load;
  logic              tm_clear;
  logic              tm_wrap;
  logic              tm_note_end;
  logic              tm_gap_start;
  logic              tm_wrap_unused;

  assign run        = state_q != S_IDLE;
  assign start_ok   = !run && start && !stop;
  assign last_entry = idx_q == IDX_W'(SONG_LEN - 1);
  assign nxt_idx    = (!run || last_entry) ? '0 : idx_q + 1'b1;
  assign nxt        = SONG[nxt_idx];
  assign tm_wrap_unused = tm_wrap;

  always_comb begin
    tm_load  = 1'b0;
    tm_clear = 1'b0;
    if (start_ok) begin
      tm_load = 1'b1;
    end else if (run) begin
      if (stop) begin
        tm_clear = 1'b1;
      end else if (tm_note_end) begin
        tm_load  = !last_entry || loop;
        tm_clear = last_entry && !loop;
      end
    end
  end

  beat_timer #(
    .TICK_DIV   (TICK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .load_i      (tm_load),
    .beats_i     (beats_of(nxt)),
    .clear_i     (tm_clear),
    .wrap_o      (tm_wrap),
    .note_end_o  (tm_note_end),
    .gap_start_o (tm_gap_start)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          note_q <= '0;
          if (start_ok) begin
            state_q <= S_PLAY;
            idx_q   <= '0;
            note_q  <= nxt.note;
          end
        end
        S_PLAY, S_GAP: begin
          if (stop) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            idx_q   <= '0;
          end else if (tm_note_end) begin
            if (!last_entry || loop) begin
              state_q <= S_PLAY;
              idx_q   <= nxt_idx;
              note_q  <= nxt.note;
            end else begin
              state_q <= S_IDLE;
              note_q  <= '0;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end
          end else if (tm_gap_start) begin
            state_q <= S_GAP;
            note_q  <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          note_q  <= '0;
        end
      endcase
    end
  end

  assign note_bin = note_q;
  assign note_idx = idx_q;
  assign busy     = run;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized bench for melody_sequencer against a timeline model.
module tb_melody_sequencer;

  localparam int TD   = 4;
  localparam int SONG = 192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [2:0] nb, nb0;
  logic [5:0] ni, ni0;
  logic       bz, bz0, dn, dn0;

  int checks = 0;
  int passes = 0;

  int mel [42] = '{1,1,5,5,6,6,5, 4,4,3,3,2,2,1,
                   5,5,4,4,3,3,2, 5,5,4,4,3,3,2,
                   1,1,5,5,6,6,5, 4,4,3,3,2,2,1};

  always #5 clk = ~clk;

  melody_sequencer #(.TICK_DIV(TD), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop(loop), .note_bin(nb), .note_idx(ni), .busy(bz),
    .done(dn)
  );

  melody_sequencer #(.TICK_DIV(TD), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop(loop), .note_bin(nb0), .note_idx(ni0), .busy(bz0),
    .done(dn0)
  );

  // Expected output k cycles after the start edge, walking the song.
  function automatic void ref_at(input int k, input int gap,
                                 output logic [2:0] enb,
                                 output logic [5:0] eidx);
    int t;
    int dur;
    t = k % SONG;
    enb = '0;
    eidx = '0;
    for (int i = 0; i < 42; i++) begin
      dur = ((i % 7 == 6) ? 2 : 1) * TD;
      if (t < dur) begin
        eidx = 6'(i);
        enb = (t < dur - gap) ? 3'(mel[i]) : 3'd0;
        return;
      end
      t -= dur;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({nb, ni, bz, dn} !== 11'd0)
      $display("FAIL reset_outputs got %h want 0", {nb, ni, bz, dn});
    else passes++;
    #3 rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({nb, bz, dn} !== 5'd0)
      $display("FAIL idle_after_reset got %h want 0", {nb, bz, dn});
    else passes++;
  endtask

  task automatic test_intro();
    logic [2:0] e;
    logic [5:0] ei;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      ref_at(k, 1, e, ei);
      checks++;
      if (nb !== e)
        $display("FAIL intro_note k=%0d got %0d want %0d", k, nb, e);
      else passes++;
      checks++;
      if (ni !== ei)
        $display("FAIL intro_idx k=%0d got %0d want %0d", k, ni, ei);
      else passes++;
      checks++;
      if (bz !== 1'b1)
        $display("FAIL intro_busy k=%0d got %b want 1", k, bz);
      else passes++;
      if (k < 8) begin
        ref_at(k, 0, e, ei);
        checks++;
        if (nb0 !== e)
          $display("FAIL nogap_note k=%0d got %0d want %0d", k, nb0, e);
        else passes++;
      end
      tick();
    end
    pulse_stop();
  endtask

  task automatic test_full_noloop();
    logic [2:0] e;
    logic [5:0] ei;
    loop = 1'b0;
    pulse_start();
    for (int k = 0; k < SONG; k++) begin
      ref_at(k, 1, e, ei);
      checks++;
      if (nb !== e || ni !== ei)
        $display("FAIL song_step k=%0d got %0d/%0d want %0d/%0d",
                 k, nb, ni, e, ei);
      else passes++;
      checks++;
      if (bz !== 1'b1 || dn !== 1'b0)
        $display("FAIL song_flags k=%0d got busy=%b done=%b want 1/0",
                 k, bz, dn);
      else passes++;
      loop = (k < 180) ? 1'($urandom % 2) : 1'b0;
      tick();
    end
    checks++;
    if (dn !== 1'b1 || bz !== 1'b0 || nb !== 3'd0)
      $display("FAIL song_end got done=%b busy=%b note=%0d want 1/0/0",
               dn, bz, nb);
    else passes++;
    tick();
    checks++;
    if (dn !== 1'b0 || bz !== 1'b0 || nb !== 3'd0)
      $display("FAIL after_end got done=%b busy=%b note=%0d want 0/0/0",
               dn, bz, nb);
    else passes++;
  endtask

  task automatic test_loop();
    logic [2:0] e;
    logic [5:0] ei;
    int mid;
    mid = $urandom_range(20, 150);
    loop = 1'b1;
    pulse_start();
    for (int k = 0; k < SONG + 24; k++) begin
      ref_at(k, 1, e, ei);
      checks++;
      if (nb !== e || ni !== ei)
        $display("FAIL loop_step k=%0d got %0d/%0d want %0d/%0d",
                 k, nb, ni, e, ei);
      else passes++;
      checks++;
      if (bz !== 1'b1 || dn !== 1'b0)
        $display("FAIL loop_flags k=%0d got busy=%b done=%b want 1/0",
                 k, bz, dn);
      else passes++;
      start = (k == mid);
      loop = (k >= 170 && k < 200) ? 1'b1 : 1'($urandom % 2);
      tick();
    end
    start = 1'b0;
    loop = 1'b0;
    pulse_stop();
    checks++;
    if (bz !== 1'b0 || nb !== 3'd0)
      $display("FAIL loop_stop got busy=%b note=%0d want 0/0", bz, nb);
    else passes++;
  endtask

  task automatic test_stop_start();
    pulse_start();
    repeat (10) tick();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if ({nb, ni, bz, dn} !== 11'd0)
      $display("FAIL stop_wins got %h want 0", {nb, ni, bz, dn});
    else passes++;
    pulse_stop();
    repeat (2) tick();
    checks++;
    if ({nb, bz, dn} !== 5'd0)
      $display("FAIL stop_idle got %h want 0", {nb, bz, dn});
    else passes++;
  endtask

  task automatic test_async_reset();
    int n;
    n = $urandom_range(3, 100);
    pulse_start();
    repeat (n) tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (nb !== 3'd0 || bz !== 1'b0 || ni !== 6'd0)
      $display("FAIL async_reset got %0d/%b/%0d want 0/0/0", nb, bz, ni);
    else passes++;
    checks++;
    if (nb0 !== 3'd0 || bz0 !== 1'b0)
      $display("FAIL async_reset0 got %0d/%b want 0/0", nb0, bz0);
    else passes++;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (nb !== 3'd0 || bz !== 1'b0)
        $display("FAIL post_reset k=%0d got %0d/%b want 0/0", k, nb, bz);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_intro();
    test_full_noloop();
    test_loop();
    test_stop_start();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
